// File: rtl/ro_entropy_pkg.sv
// Shared types and defaults for the ring-oscillator entropy source.
package ro_entropy_pkg;

    localparam int unsigned DEF_NUM_RO      = 4;
    localparam int unsigned DEF_BASE_STAGES = 13;
    localparam int unsigned DEF_WORD_WIDTH  = 16;
    localparam int unsigned DEF_SAMPLE_DIV  = 8;
    localparam int unsigned DEF_REP_LIMIT   = 32;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        STALL,
        FAIL
    } state_t;

    // Oscillator k gets a distinct odd length so the loops never lock to each other.
    function automatic int unsigned ro_stages(input int unsigned base, input int unsigned k);
        return base + 2 * k;
    endfunction

endpackage

// File: rtl/ring_oscillator.sv
// Cycle-level stand-in for a free-running ring oscillator: an odd loop of
// inverting stages, held at zero while disabled.
module ring_oscillator #(
    parameter int unsigned STAGES = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic osc
);

    logic [STAGES-1:0] stage;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            stage <= '0;
        end else begin
            stage <= ~{stage[STAGES-2:0], stage[STAGES-1]};
        end
    end

    assign osc = stage[STAGES-1];

endmodule

// File: rtl/ro_entropy_source_von_neumann_debiaser.sv
// Von Neumann debiaser: pairs successive strobed samples, emits 1 for 10,
// 0 for 01, nothing for 00/11.
module von_neumann_debiaser (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    input  logic raw,
    input  logic clear,
    output logic bit_valid,
    output logic bit_data
);

    logic second;
    logic first_bit;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            second    <= 1'b0;
            first_bit <= 1'b0;
        end else if (strobe) begin
            second <= ~second;
            if (!second) begin
                first_bit <= raw;
            end
        end
    end

    // Output is combinational on the second strobe so the packer takes it on the same edge.
    assign bit_valid = strobe && second && (raw != first_bit);
    assign bit_data  = first_bit;

endmodule

// File: rtl/ro_entropy_source.sv
// Ring-oscillator TRNG: XOR-combined oscillators, synchronised, decimated,
// debiased, packed into words behind a valid/ready port with a health test.
module ro_entropy_source
    import ro_entropy_pkg::*;
#(
    parameter int unsigned NUM_RO      = DEF_NUM_RO,
    parameter int unsigned BASE_STAGES = DEF_BASE_STAGES,
    parameter int unsigned WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int unsigned SAMPLE_DIV  = DEF_SAMPLE_DIV,
    parameter int unsigned REP_LIMIT   = DEF_REP_LIMIT
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  test_mode,
    input  logic                  test_bit,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  health_fail
);

    localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(WORD_WIDTH + 1);
    localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

    logic [NUM_RO-1:0]     osc;
    logic                  src;
    logic [1:0]            sync;
    logic                  raw_sync;
    logic [CNT_W-1:0]      sample_cnt;
    logic                  strobe;
    logic [REP_W-1:0]      rep_cnt;
    logic                  prev_raw;
    logic [WORD_WIDTH-1:0] acc;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  acc_full;
    logic                  handshake;
    logic                  out_free;
    logic                  bit_valid;
    logic                  bit_data;
    state_t                state;

    for (genvar k = 0; k < NUM_RO; k++) begin : g_ro
        ring_oscillator #(
            .STAGES(ro_stages(BASE_STAGES, k))
        ) u_ro (
            .clk   (CLOCK_50),
            .reset (reset),
            .enable(enable),
            .osc   (osc[k])
        );
    end

    assign src = test_mode ? test_bit : ^osc;

    // Synchroniser is a pure delay line of src; it is deliberately not reset.
    always_ff @(posedge CLOCK_50) begin
        sync <= {sync[0], src};
    end
    assign raw_sync = sync[1];

    assign strobe    = enable && (sample_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign acc_full  = (bit_cnt == BIT_W'(WORD_WIDTH));
    assign handshake = word_valid && word_ready;
    assign out_free  = !word_valid || handshake;

    von_neumann_debiaser u_debias (
        .clk      (CLOCK_50),
        .reset    (reset),
        .strobe   (strobe),
        .raw      (raw_sync),
        .clear    (!enable),
        .bit_valid(bit_valid),
        .bit_data (bit_data)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            word_valid  <= 1'b0;
            word_data   <= '0;
            health_fail <= 1'b0;
            sample_cnt  <= '0;
            rep_cnt     <= '0;
            prev_raw    <= 1'b0;
            acc         <= '0;
            bit_cnt     <= '0;
        end else begin
            case (state)
                FAIL: begin
                    word_valid <= 1'b0;
                end
                default: begin
                    if (rep_cnt == REP_W'(REP_LIMIT)) begin
                        health_fail <= 1'b1;
                        word_valid  <= 1'b0;
                        state       <= FAIL;
                    end else if (!enable) begin
                        sample_cnt <= '0;
                        rep_cnt    <= '0;
                        prev_raw   <= 1'b0;
                        acc        <= '0;
                        bit_cnt    <= '0;
                        if (handshake) begin
                            word_valid <= 1'b0;
                        end
                        state <= IDLE;
                    end else begin
                        if (strobe) begin
                            sample_cnt <= '0;
                            prev_raw   <= raw_sync;
                            // rep_cnt==0 means no previous sample yet
                            if (rep_cnt != '0 && raw_sync == prev_raw) begin
                                rep_cnt <= rep_cnt + REP_W'(1);
                            end else begin
                                rep_cnt <= REP_W'(1);
                            end
                        end else begin
                            sample_cnt <= sample_cnt + CNT_W'(1);
                        end

                        if (acc_full) begin
                            if (out_free) begin
                                word_data  <= acc;
                                word_valid <= 1'b1;
                                bit_cnt    <= '0;
                                state      <= COLLECT;
                            end else begin
                                state <= STALL;
                            end
                        end else begin
                            if (bit_valid) begin
                                acc     <= {acc[WORD_WIDTH-2:0], bit_data};
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                            if (handshake) begin
                                word_valid <= 1'b0;
                            end
                            state <= COLLECT;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ro_entropy_source.md
Name: ro_entropy_source

Overview:
Parametrised true-random word generator built from NUM_RO free-running ring oscillators of distinct odd lengths, XOR-combined, synchronised, decimated, von Neumann debiased and packed into WORD_WIDTH-bit words. It has a valid/ready output, a sticky repetition-count health test and a deterministic test_mode input for verification. It feeds the audio path's dither/noise generators on CLOCK_50.

Parameters:
NUM_RO, 4, number of ring oscillators; oscillator k has BASE_STAGES+2*k inverter stages.
BASE_STAGES, 13, stage count of oscillator 0 (odd, >=3).
WORD_WIDTH, 16, output word width (>=2).
SAMPLE_DIV, 8, CLOCK_50 cycles per raw sample (>=1).
REP_LIMIT, 32, consecutive identical raw samples that trip the health test (>=2).

Ports:
CLOCK_50  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
enable  in  1  runs the oscillators and the sampling pipeline.
test_mode  in  1  1: raw source is test_bit instead of the oscillator XOR.
test_bit  in  1  deterministic raw-source bit, used when test_mode=1.
word_valid  out  1  word_data holds an unconsumed word.
word_ready  in  1  consumer accepts when word_valid && word_ready.
word_data  out  WORD_WIDTH  random word.
health_fail  out  1  sticky repetition-count failure flag.

Behaviour:
- Reset: word_valid=0, word_data=0, health_fail=0. Sample counter, pair flag, accumulator, bit count and repetition counter are all 0.
- Source: src = test_mode ? test_bit : XOR of all oscillator outputs. Oscillators are held at 0 when enable=0. src passes through a 2-flop synchroniser, so a raw sample reflects src from 2 cycles earlier.
- Sampling: while enable=1, the sample counter runs 0..SAMPLE_DIV-1 and wraps. A strobe fires when the count is SAMPLE_DIV-1; for SAMPLE_DIV=1 it fires every cycle. On each strobe, raw = synchroniser output.
- Health test: on each strobe, if raw equals the previous raw sample, rep_cnt increments; otherwise rep_cnt resets to 1. When rep_cnt reaches REP_LIMIT, health_fail is set on the next edge.
- health_fail is cleared only by reset. While health_fail=1: word_valid is forced 0, the pending word is discarded, and accumulation stops.
- Debias: strobes alternate first/second of a pair. First sample is latched. On the second: 10 emits 1, 01 emits 0, 00 and 11 emit nothing. The pair flag always returns to "first".
- Pack: each emitted bit enters acc = {acc[WORD_WIDTH-2:0], bit} and bit count increments. The first emitted bit ends up at the MSB.
- Accumulator full (count==WORD_WIDTH):
  - If the output register is empty, or a handshake occurs in the same cycle, acc moves to word_data, word_valid=1 and count=0, all on the same edge.
  - Otherwise the accumulator stalls and emitted bits are dropped.
- Output: word_data is stable while word_valid && !word_ready. On a handshake with no transfer pending, word_valid drops to 0 on the next edge. On a handshake with a simultaneous transfer, word_valid stays 1 and the new word appears.
- State machine: IDLE (enable=0), COLLECT, STALL (acc full, output occupied), FAIL (absorbing until reset).
- enable 1→0: sample counter, pair flag, accumulator, count and rep_cnt are cleared. A pending output word remains until consumed.
- Reset mid-word: all partial state is lost, and the first strobe after reset starts a new pair.

Decomposition:
- Shared package ro_entropy_pkg holds:
  - the state enum (IDLE, COLLECT, STALL, FAIL);
  - the function ro_stages(k) = BASE_STAGES+2*k;
  - the default-parameter constants.
- The existing ring_oscillator is instantiated NUM_RO times in a generate loop.
- The one natural new sub-module is von_neumann_debiaser: pair flag and first-bit latch, with inputs strobe/raw/clear and outputs bit_valid/bit.

Test Plan:
(bench overrides: WORD_WIDTH=8, SAMPLE_DIV=1, REP_LIMIT=8, test_mode=1)
1. Reset held 3 cycles with test_bit toggling → word_valid=0, word_data=8'h00, health_fail=0 throughout.
2. enable=1, word_ready=1, test_bit pairs 10,01 repeated 4 times (16 samples) → exactly one word 8'hAA with word_valid high for 1 cycle; word_valid rises one edge after the 16th sample reaches the raw stage (2-cycle synchroniser latency).
3. Pairs 00,11,00,11 interleaved with eight 10 pairs → 8'hFF; the 00/11 pairs add nothing to the bit count, and rep_cnt never reaches 8.
4. word_ready=0, alternating 10/01 pairs to fill three words → first word (8'hAA) held stable; accumulator stalls and third-word bits are dropped. Raising word_ready for 1 cycle then gives the second word (8'hAA) with no word_valid gap. Raising it again drops word_valid.
5. test_bit held 1 for 8 samples → health_fail=1 on the edge after the 8th sample and word_valid=0. health_fail stays set through an enable toggle and clears only after a reset pulse.
6. Reset asserted after 5 emitted bits, then 8 pairs of 01 → word 8'h00, proving the partial word was discarded.
